cpu_boot_ctrl: RTL and testbench

Boot and run controller for the pipelined RISC-V core. It streams a program in byte-wide over the dedicated input pins and assembles 32-bit instruction words into instruction memory. It holds the core in reset while loading, then releases it and gates its execution until a halt request. It sits between the top-level pin wrapper and the `pipelined_risc_v_cpu` instance.

---
 rtl/cpu_boot_ctrl_if.sv | 12 +
 rtl/cpu_boot_ctrl.sv | 129 ++++++++++++
 tb/tb_cpu_boot_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_boot_ctrl_if.sv
// Instruction-memory write port from the boot controller to the core's instruction RAM.
// Handshake: imem_we is a one-cycle write strobe that qualifies imem_addr/imem_wdata; there is no ready, so the memory accepts every strobed word.
interface cpu_boot_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (output imem_we, imem_addr, imem_wdata);
    modport slave  (input  imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/cpu_boot_ctrl.sv
// Boot/run controller: assembles strobed bytes into instruction words, then
// releases and gates the core until a halt or reload.
module cpu_boot_ctrl #(
    parameter int IMEM_DEPTH = 64,
    parameter int ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_mode,
    input  logic              byte_strb,
    input  logic [7:0]        data_in,
    input  logic              halt_req,
    cpu_boot_ctrl_if.master   imem,
    output logic              cpu_rst_n,
    output logic              cpu_en,
    output logic [1:0]        state,
    output logic [ADDR_W:0]   words_loaded,
    output logic [15:0]       run_cycles
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_W = IMEM_DEPTH[ADDR_W:0];

    state_t            state_q, state_d;
    logic              strb_q;
    logic [1:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [15:0]       run_q, run_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              cpu_en_q, cpu_en_d;
    logic              strb_edge;
    logic              full;
    logic              load_entry;

    assign strb_edge  = byte_strb & ~strb_q;
    assign full       = (words_q == DEPTH_W);
    assign load_entry = (state_d == S_LOAD) && (state_q != S_LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            strb_q      <= 1'b0;
            cnt_q       <= 2'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            words_q     <= '0;
            run_q       <= 16'd0;
            cpu_rst_n_q <= 1'b0;
            cpu_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            strb_q      <= byte_strb;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            words_q     <= words_d;
            run_q       <= run_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            cpu_en_q    <= cpu_en_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        words_d     = words_q;
        run_d       = run_q;

        case (state_q)
            S_IDLE:  state_d = load_mode ? S_LOAD : S_RUN;
            S_LOAD:  if (!load_mode) state_d = S_RUN;
            S_RUN: begin
                if (load_mode)     state_d = S_LOAD;
                else if (halt_req) state_d = S_HALT;
            end
            S_HALT:  if (load_mode) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase

        // The write pulse retires at its closing edge, even if LOAD was already left.
        if (we_q) begin
            addr_d = addr_q + 1'b1;
            if (!full) words_d = words_q + 1'b1;
        end

        if ((state_q == S_LOAD) && strb_edge && !full) begin
            wdata_d[{cnt_q, 3'b000} +: 8] = data_in;
            cnt_d = cnt_q + 2'd1;
            we_d  = (cnt_q == 2'd3);
        end

        if (load_entry) begin
            cnt_d   = 2'd0;
            addr_d  = '0;
            words_d = '0;
        end

        cpu_rst_n_d = (state_d == S_RUN) || (state_d == S_HALT);
        cpu_en_d    = (state_d == S_RUN);

        // Only a fresh start (from IDLE or LOAD) restarts the cycle count.
        if ((state_d == S_RUN) && ((state_q == S_IDLE) || (state_q == S_LOAD)))
            run_d = 16'd0;
        else if (cpu_en_q && (run_q != 16'hFFFF))
            run_d = run_q + 16'd1;
    end

    assign imem.imem_we    = we_q;
    assign imem.imem_addr  = addr_q;
    assign imem.imem_wdata = wdata_q;
    assign cpu_rst_n       = cpu_rst_n_q;
    assign cpu_en          = cpu_en_q;
    assign state           = state_q;
    assign words_loaded    = words_q;
    assign run_cycles      = run_q;
endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Directed bench for cpu_boot_ctrl: vector table for the basic load/run/halt
// flow, hand sequences for partial words, overflow, priority and reset.
module tb_cpu_boot_ctrl;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_mode = 1'b1;
    logic              byte_strb = 1'b0;
    logic [7:0]        data_in = 8'd0;
    logic              halt_req = 1'b0;
    logic              cpu_rst_n;
    logic              cpu_en;
    logic [1:0]        state;
    logic [ADDR_W:0]   words_loaded;
    logic [15:0]       run_cycles;

    cpu_boot_ctrl_if #(.ADDR_W(ADDR_W)) imem_bus ();

    cpu_boot_ctrl #(.IMEM_DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_mode    (load_mode),
        .byte_strb    (byte_strb),
        .data_in      (data_in),
        .halt_req     (halt_req),
        .imem         (imem_bus.master),
        .cpu_rst_n    (cpu_rst_n),
        .cpu_en       (cpu_en),
        .state        (state),
        .words_loaded (words_loaded),
        .run_cycles   (run_cycles)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int writes_seen = 0;
    logic [ADDR_W+31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        byte_strb = 1'b1;
        data_in   = d;
        tick();
        byte_strb = 1'b0;
        tick();
    endtask

    // scoreboard: every write pulse must match the head of exp_q
    always @(negedge clk) begin
        if (rst_n && imem_bus.imem_we) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h", imem_bus.imem_addr, imem_bus.imem_wdata);
            end else begin
                logic [ADDR_W+31:0] e;
                e = exp_q.pop_front();
                chk("write_addr", 32'(imem_bus.imem_addr), 32'(e[ADDR_W+31:32]));
                chk("write_data", imem_bus.imem_wdata, e[31:0]);
            end
        end
    end

    typedef struct {
        logic        lm;
        logic        st;
        logic [7:0]  d;
        logic        hr;
        logic [1:0]  e_state;
        logic        e_we;
        logic [5:0]  e_addr;
        logic [31:0] e_wdata;
        logic [6:0]  e_words;
        logic        e_rn;
        logic        e_en;
        logic [15:0] e_rc;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(input logic lm, input logic st, input logic [7:0] d, input logic hr,
                                input logic [1:0] es, input logic ew, input logic [5:0] ea,
                                input logic [31:0] ewd, input logic [6:0] ewl, input logic ern,
                                input logic een, input logic [15:0] erc);
        vec_t v;
        v.lm = lm; v.st = st; v.d = d; v.hr = hr;
        v.e_state = es; v.e_we = ew; v.e_addr = ea; v.e_wdata = ewd;
        v.e_words = ewl; v.e_rn = ern; v.e_en = een; v.e_rc = erc;
        return v;
    endfunction

    task automatic check_outputs(input string tag, input logic [1:0] es, input logic ew,
                                 input logic [5:0] ea, input logic [31:0] ewd, input logic [6:0] ewl,
                                 input logic ern, input logic een, input logic [15:0] erc);
        chk({tag, " state"}, 32'(state), 32'(es));
        chk({tag, " imem_we"}, 32'(imem_bus.imem_we), 32'(ew));
        chk({tag, " imem_addr"}, 32'(imem_bus.imem_addr), 32'(ea));
        chk({tag, " imem_wdata"}, imem_bus.imem_wdata, ewd);
        chk({tag, " words_loaded"}, 32'(words_loaded), 32'(ewl));
        chk({tag, " cpu_rst_n"}, 32'(cpu_rst_n), 32'(ern));
        chk({tag, " cpu_en"}, 32'(cpu_en), 32'(een));
        chk({tag, " run_cycles"}, 32'(run_cycles), 32'(erc));
    endtask

    initial begin
        //             lm st  d      hr  st we addr wdata          wl rn en rc
        vecs[0]  = mk(1, 0, 8'h00, 0, 1, 0, 0, 32'h00000000, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 8'h13, 0, 1, 0, 0, 32'h00000013, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 8'h00, 0, 1, 0, 0, 32'h00000013, 0, 0, 0, 0);
        vecs[3]  = mk(1, 1, 8'h00, 0, 1, 0, 0, 32'h00000013, 0, 0, 0, 0);
        vecs[4]  = mk(1, 0, 8'h00, 0, 1, 0, 0, 32'h00000013, 0, 0, 0, 0);
        vecs[5]  = mk(1, 1, 8'h00, 0, 1, 0, 0, 32'h00000013, 0, 0, 0, 0);
        vecs[6]  = mk(1, 0, 8'h00, 0, 1, 0, 0, 32'h00000013, 0, 0, 0, 0);
        vecs[7]  = mk(1, 1, 8'h00, 0, 1, 1, 0, 32'h00000013, 0, 0, 0, 0);
        vecs[8]  = mk(1, 0, 8'h00, 0, 1, 0, 1, 32'h00000013, 1, 0, 0, 0);
        vecs[9]  = mk(1, 1, 8'h11, 0, 1, 0, 1, 32'h00000011, 1, 0, 0, 0);
        vecs[10] = mk(1, 0, 8'h00, 0, 1, 0, 1, 32'h00000011, 1, 0, 0, 0);
        vecs[11] = mk(1, 1, 8'h22, 0, 1, 0, 1, 32'h00002211, 1, 0, 0, 0);
        vecs[12] = mk(1, 0, 8'h00, 0, 1, 0, 1, 32'h00002211, 1, 0, 0, 0);
        vecs[13] = mk(1, 1, 8'h33, 0, 1, 0, 1, 32'h00332211, 1, 0, 0, 0);
        vecs[14] = mk(1, 0, 8'h00, 0, 1, 0, 1, 32'h00332211, 1, 0, 0, 0);
        vecs[15] = mk(1, 1, 8'h44, 0, 1, 1, 1, 32'h44332211, 1, 0, 0, 0);
        vecs[16] = mk(1, 0, 8'h00, 0, 1, 0, 2, 32'h44332211, 2, 0, 0, 0);
        vecs[17] = mk(0, 0, 8'h00, 0, 2, 0, 2, 32'h44332211, 2, 1, 1, 0);
        vecs[18] = mk(0, 0, 8'h00, 0, 2, 0, 2, 32'h44332211, 2, 1, 1, 1);
        vecs[19] = mk(0, 1, 8'hFF, 0, 2, 0, 2, 32'h44332211, 2, 1, 1, 2);
        vecs[20] = mk(0, 0, 8'h00, 1, 3, 0, 2, 32'h44332211, 2, 1, 0, 3);
        vecs[21] = mk(0, 0, 8'h00, 0, 3, 0, 2, 32'h44332211, 2, 1, 0, 3);
        vecs[22] = mk(0, 0, 8'h00, 0, 3, 0, 2, 32'h44332211, 2, 1, 0, 3);

        // reset state
        #2;
        check_outputs("reset", 2'd0, 1'b0, 6'd0, 32'd0, 7'd0, 1'b0, 1'b0, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        exp_q.push_back({6'd0, 32'h00000013});
        exp_q.push_back({6'd1, 32'h44332211});
        for (int i = 0; i < 23; i++) begin
            load_mode = vecs[i].lm;
            byte_strb = vecs[i].st;
            data_in   = vecs[i].d;
            halt_req  = vecs[i].hr;
            tick();
            check_outputs($sformatf("v%0d", i), vecs[i].e_state, vecs[i].e_we, vecs[i].e_addr,
                          vecs[i].e_wdata, vecs[i].e_words, vecs[i].e_rn, vecs[i].e_en, vecs[i].e_rc);
        end
        chk("table_writes", 32'(writes_seen), 32'd2);

        // HALT -> LOAD, 6 bytes then leave: the partial second word is dropped
        load_mode = 1'b1;
        tick();
        chk("reload state", 32'(state), 32'd1);
        chk("reload cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("reload words", 32'(words_loaded), 32'd0);
        chk("reload addr", 32'(imem_bus.imem_addr), 32'd0);
        exp_q.push_back({6'd0, 32'h04030201});
        for (int b = 1; b <= 6; b++) send_byte(8'(b));
        load_mode = 1'b0;
        tick();
        chk("partial state", 32'(state), 32'd2);
        chk("partial run_cycles", 32'(run_cycles), 32'd0);
        tick();
        tick();
        chk("partial words", 32'(words_loaded), 32'd1);
        chk("partial writes", 32'(writes_seen), 32'd3);

        // load_mode wins over halt_req in RUN
        halt_req  = 1'b1;
        load_mode = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("prio state", 32'(state), 32'd1);
        chk("prio cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("prio cpu_en", 32'(cpu_en), 32'd0);

        // fill all of memory, then 4 more bytes that must be ignored
        for (int w = 0; w < DEPTH; w++) begin
            logic [7:0] b0, b1, b2, b3;
            b0 = 8'(w);
            b1 = 8'(w) ^ 8'h5A;
            b2 = ~8'(w);
            b3 = 8'hC3;
            exp_q.push_back({6'(w), b3, b2, b1, b0});
            send_byte(b0);
            send_byte(b1);
            send_byte(b2);
            send_byte(b3);
        end
        chk("full words", 32'(words_loaded), 32'd64);
        chk("full addr_wrap", 32'(imem_bus.imem_addr), 32'd0);
        for (int b = 0; b < 4; b++) send_byte(8'h99);
        chk("overflow words", 32'(words_loaded), 32'd64);
        chk("overflow writes", 32'(writes_seen), 32'd67);

        // reset mid-word, then a fresh word must not contain stale bytes
        load_mode = 1'b0;
        tick();
        load_mode = 1'b1;
        tick();
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst_n = 1'b0;
        #2;
        check_outputs("midreset", 2'd0, 1'b0, 6'd0, 32'd0, 7'd0, 1'b0, 1'b0, 16'd0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("after_reset state", 32'(state), 32'd1);
        exp_q.push_back({6'd0, 32'hDEADBEEF});
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hAD);
        send_byte(8'hDE);
        chk("fresh wdata", imem_bus.imem_wdata, 32'hDEADBEEF);
        chk("fresh words", 32'(words_loaded), 32'd1);
        chk("fresh writes", 32'(writes_seen), 32'd68);

        // IDLE with load_mode low runs existing memory
        rst_n     = 1'b0;
        load_mode = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        chk("idle_run state", 32'(state), 32'd2);
        chk("idle_run cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        chk("idle_run cpu_en", 32'(cpu_en), 32'd1);
        chk("idle_run run_cycles", 32'(run_cycles), 32'd0);
        tick();
        chk("idle_run run_cycles+1", 32'(run_cycles), 32'd1);

        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
